hex_entry_parser: RTL and testbench
===================================

Name: hex_entry_parser

Overview:
- Sequential successor to the combinational key decoder. Consumes the receiver's ASCII byte stream (charData/charDataValid) and assembles a signed hexadecimal number of up to NDIGITS digits, terminated by a configurable character.
- Presents the completed value with a one-cycle valid pulse. Reports malformed entry with an error pulse and ESC-abort with an abort pulse.
- Sits between the UART receiver and command/register logic.

Parameters:
NDIGITS, 4, maximum hex digits per entry (1..8); value width W = 4*NDIGITS
SIGN_EN, 1, 1 = a single leading '+' or '-' is accepted; 0 = sign chars are errors
TERM_CHAR, 8'h0D, ASCII terminator that completes an entry
UPPER_EN, 1, 1 = 'A'-'F' accepted in addition to 'a'-'f'

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
charData  input  8  ASCII byte from receiver
charDataValid  input  1  charData is valid this cycle; one byte per valid cycle
value_out  output  W  last completed value, two's complement
value_neg  output  1  last completed value carried '-'
value_valid  output  1  one-cycle pulse: value_out/value_neg updated
err  output  1  one-cycle pulse: entry rejected
abort  output  1  one-cycle pulse: ESC received while an entry was in progress
busy  output  1  high while in SIGNED or DIGITS state
digit_cnt  output  $clog2(NDIGITS+1)  digits accepted in the current entry

Behaviour:
- Reset (async assert, sync release): state IDLE; accumulator, value_out, value_neg, digit_cnt = 0; value_valid, err, abort, busy = 0. Reset mid-entry discards the partial entry with no pulses.
- Bytes are sampled only on rising clk with charDataValid = 1. Cycles with charDataValid = 0 change nothing except clearing pulse outputs.
- Character classes:
  - digit: 0x30-0x39 -> 0-9; 0x61-0x66 -> 10-15; 0x41-0x46 -> 10-15 when UPPER_EN.
  - 0x3A-0x3F are NOT digits.
  - sign: 0x2B '+', 0x2D '-'.
  - esc: 0x1B.
  - term: TERM_CHAR.
  - Everything else is invalid.
- States: IDLE, SIGNED (sign seen, no digits yet), DIGITS.
- IDLE transitions:
  - digit -> load acc = nibble, cnt = 1, go to DIGITS.
  - sign with SIGN_EN -> latch neg ('-' = 1), go to SIGNED.
  - esc -> stay IDLE, no pulse.
  - term, invalid, or sign with !SIGN_EN -> err pulse, stay IDLE.
- SIGNED transitions:
  - digit -> as in IDLE, neg retained.
  - esc -> abort pulse, go to IDLE.
  - term, sign, or invalid -> err pulse, go to IDLE.
- DIGITS transitions:
  - digit with cnt < NDIGITS -> acc = {acc[W-5:0], nibble}, cnt + 1.
  - digit with cnt == NDIGITS -> err pulse, go to IDLE (overflow, entry discarded).
  - term -> commit, go to IDLE.
  - esc -> abort pulse, go to IDLE.
  - sign or invalid -> err pulse, go to IDLE.
- Commit:
  - value_out = neg ? (~acc + 1) mod 2^W : acc.
  - value_neg = neg.
  - value_valid pulses the cycle after the terminator byte's sampling edge (latency 1).
- value_out and value_neg hold until the next commit. err and abort never alter them.
- Leaving an entry for IDLE by any path clears acc, cnt and neg.
- At most one of value_valid, err, abort is high in any cycle. Each pulse is exactly one cycle, even when a valid byte arrives on every cycle.
- "-0" commits value_out = 0 with value_neg = 1.
- busy and digit_cnt are registered and reflect the state after the latest sampled byte.

Test Plan:
- NDIGITS=4. Bytes '-','1','a',0x0D on consecutive cycles -> one cycle after 0x0D: value_valid = 1, value_out = 16'hFFE6, value_neg = 1; busy = 0.
- Bytes '0','0','F','f',0x0D with UPPER_EN=1 -> value_out = 16'h00FF. Rerun with UPPER_EN=0 -> err pulse on 'F', no value_valid, value_out unchanged.
- Bytes '1','2','3','4','5' -> err pulse after '5'. Then '7',0x0D -> value_out = 16'h0007, proving state was cleared.
- Bytes '+','3',0x1B -> abort pulse, no value_valid. Then 0x1B from IDLE -> no pulse. Then ':' -> err pulse.
- Bytes '9','9' with charDataValid toggling 1/0/1, then rst_n low for 1 cycle, then 0x0D -> err pulse (terminator from IDLE). value_out = 0, no value_valid.
- SIGN_EN=0: byte '-' -> err. Bytes 'b',0x0D -> value_out = 16'h000B, value_neg = 0.

Source files
------------

// File: rtl/hex_entry_parser.sv
// Assembles a signed hex number from an ASCII byte stream, terminated by TERM_CHAR.
// Emits one-cycle value_valid / err / abort pulses; value_out holds until the next commit.
//   state     | meaning
//   ST_IDLE   | no entry in progress
//   ST_SIGNED | sign seen, no digits yet
//   ST_DIGITS | at least one digit accepted
module hex_entry_parser #(
  parameter int unsigned NDIGITS   = 4,
  parameter bit          SIGN_EN   = 1'b1,
  parameter logic [7:0]  TERM_CHAR = 8'h0D,
  parameter bit          UPPER_EN  = 1'b1,
  localparam int unsigned W  = 4 * NDIGITS,
  localparam int unsigned CW = $clog2(NDIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    charData,
  input  logic          charDataValid,
  output logic [W-1:0]  value_out,
  output logic          value_neg,
  output logic          value_valid,
  output logic          err,
  output logic          abort,
  output logic          busy,
  output logic [CW-1:0] digit_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_SIGNED, ST_DIGITS} state_t;

  localparam logic [CW-1:0] MAX_CNT = CW'(NDIGITS);

  state_t        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_q, neg_d;
  logic [W-1:0]  value_q, value_d;
  logic          value_neg_q, value_neg_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          abort_q, abort_d;
  logic          busy_q, busy_d;

  logic       is_digit, is_esc, is_term, is_sign, clear;
  logic [3:0] nibble;

  always_comb begin
    is_digit = 1'b0;
    nibble   = 4'd0;
    if (charData >= 8'h30 && charData <= 8'h39) begin
      is_digit = 1'b1;
      nibble   = charData[3:0];
    end else if (charData >= 8'h61 && charData <= 8'h66) begin
      is_digit = 1'b1;
      nibble   = charData[3:0] + 4'd9;
    end else if (UPPER_EN && charData >= 8'h41 && charData <= 8'h46) begin
      is_digit = 1'b1;
      nibble   = charData[3:0] + 4'd9;
    end
    // Digit and ESC classes take priority should TERM_CHAR collide with them.
    is_esc  = !is_digit && (charData == 8'h1B);
    is_term = !is_digit && !is_esc && (charData == TERM_CHAR);
    is_sign = (charData == 8'h2B) || (charData == 8'h2D);
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    value_d     = value_q;
    value_neg_d = value_neg_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    abort_d     = 1'b0;
    clear       = 1'b0;
    if (charDataValid) begin
      unique case (state_q)
        ST_IDLE, ST_SIGNED: begin
          if (is_digit) begin
            acc_d   = W'(nibble);
            cnt_d   = CW'(1);
            state_d = ST_DIGITS;
          end else if (is_esc) begin
            abort_d = (state_q == ST_SIGNED);
            clear   = 1'b1;
          end else if (is_sign && SIGN_EN && state_q == ST_IDLE) begin
            neg_d   = (charData == 8'h2D);
            state_d = ST_SIGNED;
          end else begin
            err_d = 1'b1;
            clear = 1'b1;
          end
        end
        ST_DIGITS: begin
          if (is_digit && cnt_q != MAX_CNT) begin
            acc_d = W'({acc_q, nibble});
            cnt_d = cnt_q + CW'(1);
          end else if (is_term) begin
            value_d     = neg_q ? (~acc_q + W'(1)) : acc_q;
            value_neg_d = neg_q;
            valid_d     = 1'b1;
            clear       = 1'b1;
          end else if (is_esc) begin
            abort_d = 1'b1;
            clear   = 1'b1;
          end else begin
            err_d = 1'b1;
            clear = 1'b1;
          end
        end
        default: clear = 1'b1;
      endcase
    end
    if (clear) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      neg_d   = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      value_q     <= '0;
      value_neg_q <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      value_q     <= value_d;
      value_neg_q <= value_neg_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      abort_q     <= abort_d;
      busy_q      <= busy_d;
    end
  end

  assign value_out   = value_q;
  assign value_neg   = value_neg_q;
  assign value_valid = valid_q;
  assign err         = err_q;
  assign abort       = abort_q;
  assign busy        = busy_q;
  assign digit_cnt   = cnt_q;

endmodule

// File: tb/tb_hex_entry_parser.sv
// Scoreboarded bench: two parser instances (full features / no sign, no upper case)
// share one byte stream; an entry-level model predicts every cycle's outputs.
module tb_hex_entry_parser;
  localparam int ND = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  charData = 8'h00;
  logic        charDataValid = 1'b0;

  logic [15:0] val_a, val_b;
  logic        neg_a, neg_b, vv_a, vv_b, err_a, err_b, ab_a, ab_b, busy_a, busy_b;
  logic [2:0]  cnt_a, cnt_b;

  hex_entry_parser dut_a (
    .clk(clk), .rst_n(rst_n), .charData(charData), .charDataValid(charDataValid),
    .value_out(val_a), .value_neg(neg_a), .value_valid(vv_a), .err(err_a),
    .abort(ab_a), .busy(busy_a), .digit_cnt(cnt_a));

  hex_entry_parser #(.SIGN_EN(1'b0), .UPPER_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .charData(charData), .charDataValid(charDataValid),
    .value_out(val_b), .value_neg(neg_b), .value_valid(vv_b), .err(err_b),
    .abort(ab_b), .busy(busy_b), .digit_cnt(cnt_b));

  always #5 clk = ~clk;

  typedef struct {
    int   due;
    logic busy;
    int   cnt;
    int   val;
    logic neg;
    logic vv;
    logic er;
    logic ab;
  } exp_t;

  exp_t exp_q[2][$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: an entry is a sign flag plus a list of digit values.
  logic m_sign[2];
  logic m_neg[2];
  int   m_dig[2][$];
  int   m_val[2];
  logic m_vneg[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string nm, input int k, input longint act, input longint ex);
    n_cmp++;
    if (act != ex) begin
      n_bad++;
      $display("FAIL %s[dut%0d] @cyc %0d: got %0h, expected %0h", nm, k, cyc, act, ex);
    end
  endtask

  function automatic int hexval(input logic [7:0] c, input bit upper_en);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    if (upper_en && c >= "A" && c <= "F") return int'(c) - 55;
    return -1;
  endfunction

  task automatic m_clear(input int k);
    m_sign[k] = 1'b0;
    m_neg[k]  = 1'b0;
    m_dig[k].delete();
  endtask

  task automatic model_step(input int k, input logic [7:0] c, input logic vld,
                            input bit sign_en, input bit upper_en, output exp_t e);
    int d;
    int v;
    bit in_entry;
    e.due = 0; e.vv = 1'b0; e.er = 1'b0; e.ab = 1'b0;
    in_entry = m_sign[k] || (m_dig[k].size() > 0);
    if (vld) begin
      d = hexval(c, upper_en);
      if (d >= 0) begin
        if (m_dig[k].size() == ND) begin
          e.er = 1'b1;
          m_clear(k);
        end else m_dig[k].push_back(d);
      end else if (c == 8'h1B) begin
        e.ab = in_entry;
        m_clear(k);
      end else if (c == 8'h0D) begin
        if (m_dig[k].size() > 0) begin
          v = 0;
          foreach (m_dig[k][i]) v = v * 16 + m_dig[k][i];
          if (m_neg[k]) v = (65536 - v) % 65536;
          m_val[k]  = v;
          m_vneg[k] = m_neg[k];
          e.vv = 1'b1;
        end else e.er = 1'b1;
        m_clear(k);
      end else if ((c == 8'h2B || c == 8'h2D) && sign_en && !in_entry) begin
        m_sign[k] = 1'b1;
        m_neg[k]  = (c == 8'h2D);
      end else begin
        e.er = 1'b1;
        m_clear(k);
      end
    end
    e.busy = m_sign[k] || (m_dig[k].size() > 0);
    e.cnt  = m_dig[k].size();
    e.val  = m_val[k];
    e.neg  = m_vneg[k];
  endtask

  task automatic drive(input logic [7:0] c, input logic vld);
    exp_t e;
    @(posedge clk); #1;
    charData = c;
    charDataValid = vld;
    model_step(0, c, vld, 1'b1, 1'b1, e);
    e.due = cyc + 1;
    exp_q[0].push_back(e);
    model_step(1, c, vld, 1'b0, 1'b0, e);
    e.due = cyc + 1;
    exp_q[1].push_back(e);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) drive(s[i], 1'b1);
  endtask

  // Lets the last driven byte be checked, then pulses reset for one cycle.
  task automatic pulse_reset();
    exp_t e;
    @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b0;
    charDataValid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_clear(k);
      m_val[k] = 0;
      m_vneg[k] = 1'b0;
      e.due = cyc + 1; e.busy = 1'b0; e.cnt = 0; e.val = 0; e.neg = 1'b0;
      e.vv = 1'b0; e.er = 1'b0; e.ab = 1'b0;
      exp_q[k].push_back(e);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic sb(input int k, input logic [15:0] v, input logic n, input logic vv,
                    input logic er, input logic ab, input logic bz, input logic [2:0] c);
    exp_t e;
    while (exp_q[k].size() > 0 && exp_q[k][0].due < cyc) begin
      e = exp_q[k].pop_front();
      cmp("stale_expectation_due", k, e.due, cyc);
    end
    if (exp_q[k].size() > 0 && exp_q[k][0].due == cyc) begin
      e = exp_q[k].pop_front();
      cmp("value_valid", k, vv, e.vv);
      cmp("err", k, er, e.er);
      cmp("abort", k, ab, e.ab);
      cmp("busy", k, bz, e.busy);
      cmp("digit_cnt", k, c, e.cnt);
      cmp("value_out", k, v, e.val);
      cmp("value_neg", k, n, e.neg);
    end else if (vv || er || ab) begin
      cmp("unexpected_pulse", k, {vv, er, ab}, 0);
    end
  endtask

  always @(negedge clk) begin
    sb(0, val_a, neg_a, vv_a, err_a, ab_a, busy_a, cnt_a);
    sb(1, val_b, neg_b, vv_b, err_b, ab_b, busy_b, cnt_b);
  end

  function automatic logic [7:0] rnd_char();
    int r;
    logic [7:0] hx;
    r = $urandom_range(0, 19);
    hx = 8'($urandom_range(0, 15));
    if (r <= 7) return (hx < 10) ? 8'h30 + hx : 8'h57 + hx;
    if (r <= 9) return 8'h41 + 8'($urandom_range(0, 5));
    if (r <= 12) return 8'h0D;
    if (r == 13) return 8'h2B;
    if (r == 14) return 8'h2D;
    if (r == 15) return 8'h1B;
    if (r == 16) return 8'h3A + 8'($urandom_range(0, 5));
    if (r == 17) return ($urandom_range(0, 1) == 1) ? 8'h47 : 8'h40;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_clear(k);
      m_val[k] = 0;
      m_vneg[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_value_out", 0, val_a, 0);
    cmp("rst_pulses", 0, {vv_a, err_a, ab_a}, 0);
    cmp("rst_busy_cnt", 0, {busy_a, cnt_a}, 0);
    cmp("rst_value_out", 1, {neg_b, val_b}, 0);
    rst_n = 1'b1;

    send_str("-1a"); drive(8'h0D, 1'b1); drive(8'h00, 1'b0);
    cmp("neg_commit_value", 0, val_a, 16'hFFE6);
    cmp("neg_commit_sign", 0, neg_a, 1);
    cmp("nosign_commit_value", 1, {neg_b, val_b}, 17'h0001A);

    send_str("00F"); drive(8'h00, 1'b0);
    cmp("upper_rejected_hold", 1, val_b, 16'h001A);
    send_str("f"); drive(8'h0D, 1'b1); drive(8'h00, 1'b0);
    cmp("upper_commit_value", 0, val_a, 16'h00FF);

    send_str("123457"); drive(8'h0D, 1'b1); drive(8'h00, 1'b0);
    cmp("after_overflow_value", 0, {neg_a, val_a}, 17'h00007);
    cmp("after_overflow_value", 1, {neg_b, val_b}, 17'h00007);

    send_str("+3"); drive(8'h1B, 1'b1); drive(8'h1B, 1'b1); send_str(":");
    drive(8'h00, 1'b0);
    cmp("abort_keeps_value", 0, val_a, 16'h0007);

    send_str("9"); drive(8'h00, 1'b0); send_str("9");
    pulse_reset();
    drive(8'h0D, 1'b1); drive(8'h00, 1'b0);
    cmp("reset_clears_value", 0, {neg_a, val_a}, 0);
    cmp("reset_clears_value", 1, {neg_b, val_b}, 0);

    send_str("-b"); drive(8'h0D, 1'b1); drive(8'h00, 1'b0);
    cmp("neg_b_value", 0, {neg_a, val_a}, 17'h1FFF5);
    cmp("sign_disabled_value", 1, {neg_b, val_b}, 17'h0000B);

    send_str("-0"); drive(8'h0D, 1'b1); drive(8'h00, 1'b0);
    cmp("neg_zero", 0, {neg_a, val_a}, 17'h10000);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) pulse_reset();
      else drive(rnd_char(), ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0);
    end

    repeat (3) drive(8'h00, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    cmp("drained_queue", 0, exp_q[0].size(), 0);
    cmp("drained_queue", 1, exp_q[1].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
